// File: rtl/iterative_pkg.sv
// Shared definitions for the iterative arithmetic blocks (divider, multiplier).
// DefaultWidth : default operand/result width; the iteration count equals the width.
// iter_state_e : common three-state sequencing FSM (idle, iterate, result ready).
package iterative_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } iter_state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem_in       : partial remainder before this step (always < divisor, or any value if divisor=0)
//   dividend_bit : next dividend bit, MSB first
//   divisor      : unsigned divisor
//   rem_out      : partial remainder after the conditional subtract
//   q_bit        : quotient bit produced by this step
module divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The shifted remainder can reach 2^(WIDTH+1)-1, so the compare is done one bit wider.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    // When the subtract succeeds the true difference is < 2^WIDTH, so the low bits are exact.
    rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_iterative.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH clocks per divide.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   valid_in  : start request; a and b are sampled on the same edge (ignored while busy)
//   a, b      : unsigned dividend and divisor
//   valid_out : one-cycle pulse while q/rem hold a fresh result
//   busy      : high while iterating
//   q, rem    : quotient and remainder; held until the next result (b=0 gives q=all-ones, rem=a)
module divider_iterative
  import iterative_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  iter_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] q_d, rem_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  // Dividend register shifts left each step so its MSB is always the next bit to consume.
  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (prem_q),
    .dividend_bit(dividend_q[WIDTH-1]),
    .divisor     (divisor_q),
    .rem_out     (step_rem),
    .q_bit       (step_qbit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    prem_d     = prem_q;
    quot_d     = quot_q;
    q_d        = q;
    rem_d      = rem;

    unique case (state_q)
      StIdle, StDone: begin
        if (valid_in) begin
          state_d    = StRun;
          cnt_d      = '0;
          dividend_d = a;
          divisor_d  = b;
          prem_d     = '0;
          quot_d     = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        prem_d     = step_rem;
        quot_d     = {quot_q[WIDTH-2:0], step_qbit};
        dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          q_d     = {quot_q[WIDTH-2:0], step_qbit};
          rem_d   = step_rem;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      prem_q     <= '0;
      quot_q     <= '0;
      q          <= '0;
      rem        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      prem_q     <= prem_d;
      quot_q     <= quot_d;
      q          <= q_d;
      rem        <= rem_d;
    end
  end

  assign valid_out = (state_q == StDone);
  assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: directed vector table, multi-cycle corner
// sequences (request during RUN, reset mid-operation, reset vs valid_in), and a
// back-to-back sweep checked against q*b+rem==a, rem<b.
// Latency convention: valid_out becomes visible just after edge 32 following the accepting
// edge and is therefore captured by edge 33.
module tb_divider_iterative;

  localparam int unsigned W = 32;
  localparam int          ExpLat = 33;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [W-1:0] a, b;
  logic         valid_out, busy;
  logic [W-1:0] q, rem;

  int n_cmp  = 0;
  int n_fail = 0;

  divider_iterative #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .a        (a),
    .b        (b),
    .valid_out(valid_out),
    .busy     (busy),
    .q        (q),
    .rem      (rem)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string        name;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] eq;
    logic [W-1:0] er;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns just after the accepting edge.
  task automatic start(input logic [W-1:0] aa, input logic [W-1:0] bb);
    valid_in = 1'b1;
    a        = aa;
    b        = bb;
    tick();
    valid_in = 1'b0;
  endtask

  // Count edges until valid_out is seen; k=0 on timeout.
  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid_out) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int           k;
    int           n_valid;
    int           first_k;
    logic [W-1:0] cap_q, cap_r;
    logic [W-1:0] aa, bb;
    logic [63:0]  recon;

    vecs[0] = '{"div_100_7",     32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{"max_by_1",      32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[2] = '{"max_by_msb",    32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF};
    vecs[3] = '{"div_by_zero",   32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[4] = '{"a_lt_b",        32'd3,          32'd10,         32'd0,          32'd3};
    vecs[5] = '{"div_50_5",      32'd50,         32'd5,          32'd10,         32'd0};
    vecs[6] = '{"zero_by_zero",  32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};
    vecs[7] = '{"hex_by_1000",   32'h1234_5678,  32'd1000,       32'd305419,     32'd896};
    vecs[8] = '{"msb_by_max",    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[9] = '{"equal",         32'd7,          32'd7,          32'd1,          32'd0};

    reset    = 1'b1;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    tick();
    tick();
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_q",         64'(q),         64'd0);
    check("rst_rem",       64'(rem),       64'd0);
    reset = 1'b0;
    tick();

    // Directed table
    foreach (vecs[i]) begin
      start(vecs[i].va, vecs[i].vb);
      check({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
      wait_valid(k);
      check({vecs[i].name, "_latency"}, 64'(k + 1), 64'(ExpLat));
      check({vecs[i].name, "_q"},   64'(q),   64'(vecs[i].eq));
      check({vecs[i].name, "_rem"}, 64'(rem), 64'(vecs[i].er));
      tick();
      check({vecs[i].name, "_pulse_len"}, 64'(valid_out), 64'd0);
      check({vecs[i].name, "_idle_busy"}, 64'(busy),      64'd0);
      check({vecs[i].name, "_q_hold"},    64'(q),         64'(vecs[i].eq));
    end

    // valid_in during RUN is ignored; previous result (7/7) must stay on q/rem meanwhile
    start(32'd100, 32'd7);
    for (int i = 1; i <= 9; i++) tick();
    check("ign_q_hold_mid", 64'(q),   64'd1);
    check("ign_r_hold_mid", 64'(rem), 64'd0);
    valid_in = 1'b1;
    a        = 32'd9;
    b        = 32'd3;
    tick();
    valid_in = 1'b0;
    n_valid  = 0;
    first_k  = 0;
    cap_q    = '0;
    cap_r    = '0;
    for (int i = 11; i <= 45; i++) begin
      tick();
      if (valid_out) begin
        n_valid++;
        if (first_k == 0) begin
          first_k = i;
          cap_q   = q;
          cap_r   = rem;
        end
      end
    end
    check("ign_n_valid", 64'(n_valid),     64'd1);
    check("ign_latency", 64'(first_k + 1), 64'(ExpLat));
    check("ign_q",       64'(cap_q),       64'd14);
    check("ign_rem",     64'(cap_r),       64'd2);

    // Reset on RUN cycle 15 aborts the operation
    start(32'd100, 32'd7);
    for (int i = 1; i <= 14; i++) tick();
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy",      64'(busy),      64'd0);
    check("abort_valid_out", 64'(valid_out), 64'd0);
    check("abort_q",         64'(q),         64'd0);
    check("abort_rem",       64'(rem),       64'd0);
    n_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_out) n_valid++;
    end
    check("abort_no_valid", 64'(n_valid), 64'd0);
    start(32'd50, 32'd5);
    wait_valid(k);
    check("after_abort_latency", 64'(k + 1), 64'(ExpLat));
    check("after_abort_q",       64'(q),     64'd10);
    check("after_abort_rem",     64'(rem),   64'd0);
    tick();

    // Reset wins over valid_in; request accepted on first edge after reset drops
    reset    = 1'b1;
    valid_in = 1'b1;
    a        = 32'd50;
    b        = 32'd5;
    tick();
    check("rst_prio_busy", 64'(busy), 64'd0);
    check("rst_prio_q",    64'(q),    64'd0);
    reset = 1'b0;
    tick();
    valid_in = 1'b0;
    check("post_rst_accept", 64'(busy), 64'd1);
    wait_valid(k);
    check("post_rst_latency", 64'(k + 1), 64'(ExpLat));
    check("post_rst_q",       64'(q),     64'd10);
    check("post_rst_rem",     64'(rem),   64'd0);
    tick();

    // Back-to-back requests, each accepted in the DONE cycle of the previous one
    aa = 32'h0000_1234;
    bb = 32'h0000_0003;
    start(aa, bb);
    for (int i = 0; i < 200; i++) begin
      wait_valid(k);
      check("b2b_latency", 64'(k + 1), 64'(ExpLat));
      if (bb == '0) begin
        check("b2b_div0_q",   64'(q),   64'hFFFF_FFFF);
        check("b2b_div0_rem", 64'(rem), 64'(aa));
      end else begin
        recon = 64'(q) * 64'(bb) + 64'(rem);
        check("b2b_recon",    recon,            64'(aa));
        check("b2b_rem_lt_b", 64'(rem < bb),    64'd1);
      end
      aa = aa + 32'h2345_6789;
      bb = bb + 32'h3456_7891;
      if (i < 199) begin
        start(aa, bb);
        check("b2b_rerun_busy", 64'(busy), 64'd1);
      end
    end
    tick();
    check("final_idle", 64'(busy | valid_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/divider_iterative.md
DIVIDER_ITERATIVE -- requirements
Module: divider_iterative

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: valid_in  input  1  request to start; samples a and b on the same edge.
REQ-005 SHALL have port: a  input  32  unsigned dividend.
REQ-006 SHALL have port: b  input  32  unsigned divisor.
REQ-007 SHALL have port: valid_out  output  1  one-cycle pulse; q and rem are valid.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress (RUN).
REQ-009 SHALL have port: q  output  32  quotient, floor(a/b).
REQ-010 SHALL have port: rem  output  32  remainder, a mod b.
REQ-011 SHALL have parameter: WIDTH, default 32, operand/result width; ITERATIONS equals WIDTH.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept a request on any rising edge with valid_in=1 while in IDLE or DONE: latch a and b, clear the iteration counter, and go to RUN.
REQ-014 SHALL ignore valid_in in RUN, leaving operands, counter and outputs undisturbed.
REQ-015 SHALL perform one restoring-division step per RUN cycle: shift the partial remainder left, insert the next dividend bit (MSB first), subtract b if no borrow, and shift the quotient bit in.
REQ-016 SHALL compute the partial-remainder/subtract path at WIDTH+1 bits so that no overflow occurs for any b, including b >= 2^31.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles, then register q and rem and enter DONE.
REQ-018 SHALL assert valid_out only in DONE, for exactly one cycle, so the first valid_out is WIDTH+1 rising edges after the accepting edge (33 for WIDTH=32).
REQ-019 SHALL go from DONE to IDLE when valid_in=0, and from DONE to RUN when valid_in=1 (back-to-back accept).
REQ-020 SHALL keep q and rem stable from DONE until the next operation's DONE; intermediate values never appear on q or rem.
REQ-021 SHALL, for b=0, return q=all-ones and rem=a with the same latency and handshake as any other request.
REQ-022 SHALL, for a<b, return q=0 and rem=a.
REQ-023 SHALL drive busy=1 exactly when the state is RUN.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, force state=IDLE, valid_out=0, busy=0, q=0, rem=0 and counter=0, regardless of state.
REQ-025 SHALL let reset abort an operation in RUN, produce no valid_out for that operation, and accept a new request on the first edge after reset deasserts.
REQ-026 SHALL give reset priority over valid_in on the same edge.

Structure
REQ-027 SHALL take the state enum (IDLE/RUN/DONE) and the WIDTH constant from the shared package iterative_pkg, which the iterative multiplier also uses.
REQ-028 SHALL instantiate the per-iteration shift/compare/subtract datapath as the combinational sub-module divider_step, with the counter and FSM kept in divider_iterative.
REQ-029 SHALL contain no latches and no combinational path from any input to any output.

Verification
REQ-030 SHALL check directed case a=100, b=7: valid_in pulsed -> valid_out exactly 33 edges later with q=14, rem=2.
REQ-031 SHALL check edge cases: a=32'hFFFFFFFF, b=1 -> q=32'hFFFFFFFF, rem=0; a=32'hFFFFFFFF, b=32'h80000000 -> q=1, rem=32'h7FFFFFFF.
REQ-032 SHALL check divide-by-zero and small dividend: a=5, b=0 -> q=32'hFFFFFFFF, rem=5; a=3, b=10 -> q=0, rem=3, each with 33-edge latency.
REQ-033 SHALL check valid_in ignored in RUN: start 100/7, pulse valid_in with a=9, b=3 at cycle 10 -> result still q=14, rem=2 and only one valid_out.
REQ-034 SHALL check reset mid-operation: assert reset at cycle 15 of RUN -> no valid_out, outputs 0; a new request 50/5 then gives q=10, rem=0.
REQ-035 SHALL run 200 back-to-back requests: a+=32'h23456789, b+=32'h34567891 per request, valid_in asserted in the DONE cycle -> each result satisfies q*b+rem==a and rem<b (or the b=0 rule).
